retorno_recirculacion: RTL and testbench

- Return-path buffer for the 4-lane recirculation stage: captures the recirculated lanes (valid_outf0..3 / outf0..3) into per-lane FIFOs and re-injects them as lane traffic when the downstream input is not paused.
- Generates the IDLE indication consumed by the recirculation stage once the return path has drained and stayed quiet.
- Sits between the recirculation block's f-outputs and its lane inputs.

---
 rtl/retorno_recirculacion.sv | 162 ++++++++++++++++
 tb/tb_retorno_recirculacion.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/retorno_recirculacion.sv
// Return-path buffer: four independent lane FIFOs that re-inject recirculated
// words when not paused, plus an idle flag once the path has drained and stayed quiet.
module retorno_recirculacion #(
  parameter int DATA_WIDTH  = 8,
  parameter int DEPTH       = 4,
  parameter int IDLE_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_inf0,
  input  logic                  valid_inf1,
  input  logic                  valid_inf2,
  input  logic                  valid_inf3,
  input  logic [DATA_WIDTH-1:0] inf0,
  input  logic [DATA_WIDTH-1:0] inf1,
  input  logic [DATA_WIDTH-1:0] inf2,
  input  logic [DATA_WIDTH-1:0] inf3,
  input  logic                  pause,
  output logic                  valid_out0,
  output logic                  valid_out1,
  output logic                  valid_out2,
  output logic                  valid_out3,
  output logic [DATA_WIDTH-1:0] out0,
  output logic [DATA_WIDTH-1:0] out1,
  output logic [DATA_WIDTH-1:0] out2,
  output logic [DATA_WIDTH-1:0] out3,
  output logic                  fifo_full0,
  output logic                  fifo_full1,
  output logic                  fifo_full2,
  output logic                  fifo_full3,
  output logic                  fifo_empty0,
  output logic                  fifo_empty1,
  output logic                  fifo_empty2,
  output logic                  fifo_empty3,
  output logic                  overflow,
  output logic                  idle
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int QW = $clog2(IDLE_CYCLES + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [QW-1:0] IDLE_C  = QW'(IDLE_CYCLES);

  logic [3:0]            valid_in;
  logic [DATA_WIDTH-1:0] data_in [4];

  logic [DATA_WIDTH-1:0] mem_q [4][DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [4][DEPTH];
  logic [PW-1:0]         wr_ptr_q [4];
  logic [PW-1:0]         wr_ptr_d [4];
  logic [PW-1:0]         rd_ptr_q [4];
  logic [PW-1:0]         rd_ptr_d [4];
  logic [CW-1:0]         count_q [4];
  logic [CW-1:0]         count_d [4];
  logic [DATA_WIDTH-1:0] out_q [4];
  logic [DATA_WIDTH-1:0] out_d [4];
  logic [3:0]            valid_out_q, valid_out_d;
  logic [3:0]            full_q, full_d;
  logic [3:0]            empty_q, empty_d;
  logic                  overflow_q, overflow_d;
  logic                  idle_q, idle_d;
  logic [QW-1:0]         quiet_cnt_q, quiet_cnt_d;
  logic [3:0]            push, pop;
  logic                  quiet;

  assign valid_in = {valid_inf3, valid_inf2, valid_inf1, valid_inf0};
  assign data_in[0] = inf0;
  assign data_in[1] = inf1;
  assign data_in[2] = inf2;
  assign data_in[3] = inf3;

  // Pop decision uses the pre-edge count, so a full lane can still accept a push
  // in the same cycle it drains one word.
  always_comb begin
    logic all_empty;
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    out_d       = out_q;
    valid_out_d = '0;
    overflow_d  = overflow_q;
    all_empty   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pop[i]  = !pause && (count_q[i] != '0);
      push[i] = valid_in[i] && ((count_q[i] != DEPTH_C) || pop[i]);
      if (pop[i]) begin
        out_d[i]       = mem_q[i][rd_ptr_q[i]];
        valid_out_d[i] = 1'b1;
        rd_ptr_d[i]    = rd_ptr_q[i] + PW'(1);
      end
      if (push[i]) begin
        mem_d[i][wr_ptr_q[i]] = data_in[i];
        wr_ptr_d[i]           = wr_ptr_q[i] + PW'(1);
      end
      if (valid_in[i] && !push[i]) begin
        overflow_d = 1'b1;
      end
      case ({push[i], pop[i]})
        2'b10:   count_d[i] = count_q[i] + CW'(1);
        2'b01:   count_d[i] = count_q[i] - CW'(1);
        default: count_d[i] = count_q[i];
      endcase
      full_d[i]  = (count_d[i] == DEPTH_C);
      empty_d[i] = (count_d[i] == '0);
      if (count_d[i] != '0) begin
        all_empty = 1'b0;
      end
    end
    quiet = all_empty && (valid_in == 4'b0000);
    if (!quiet) begin
      quiet_cnt_d = '0;
    end else if (quiet_cnt_q == IDLE_C) begin
      quiet_cnt_d = IDLE_C;
    end else begin
      quiet_cnt_d = quiet_cnt_q + QW'(1);
    end
    idle_d = quiet && (quiet_cnt_d == IDLE_C);
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '{default: '0};
      rd_ptr_q    <= '{default: '0};
      count_q     <= '{default: '0};
      out_q       <= '{default: '0};
      valid_out_q <= '0;
      full_q      <= '0;
      empty_q     <= '1;
      overflow_q  <= 1'b0;
      idle_q      <= 1'b0;
      quiet_cnt_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_q       <= out_d;
      valid_out_q <= valid_out_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      overflow_q  <= overflow_d;
      idle_q      <= idle_d;
      quiet_cnt_q <= quiet_cnt_d;
    end
  end

  assign {valid_out3, valid_out2, valid_out1, valid_out0} = valid_out_q;
  assign out0 = out_q[0];
  assign out1 = out_q[1];
  assign out2 = out_q[2];
  assign out3 = out_q[3];
  assign {fifo_full3, fifo_full2, fifo_full1, fifo_full0}     = full_q;
  assign {fifo_empty3, fifo_empty2, fifo_empty1, fifo_empty0} = empty_q;
  assign overflow = overflow_q;
  assign idle     = idle_q;

endmodule

// File: tb/tb_retorno_recirculacion.sv
// Directed bench for retorno_recirculacion (DATA_WIDTH=8, DEPTH=4, IDLE_CYCLES=2):
// a vector table for reset/idle/single-word/overflow plus hand sequences.
module tb_retorno_recirculacion;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pause = 1'b0;
  logic       valid_inf0 = 1'b0, valid_inf1 = 1'b0, valid_inf2 = 1'b0, valid_inf3 = 1'b0;
  logic [7:0] inf0 = '0, inf1 = '0, inf2 = '0, inf3 = '0;
  logic       valid_out0, valid_out1, valid_out2, valid_out3;
  logic [7:0] out0, out1, out2, out3;
  logic       fifo_full0, fifo_full1, fifo_full2, fifo_full3;
  logic       fifo_empty0, fifo_empty1, fifo_empty2, fifo_empty3;
  logic       overflow, idle;

  logic [3:0]  vout_all, full_all, empty_all;
  logic [31:0] out_all;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        rst;
    logic        pse;
    logic [3:0]  vin;
    logic [31:0] din;
    logic [3:0]  e_vout;
    logic [31:0] e_out;
    logic [3:0]  e_full;
    logic [3:0]  e_empty;
    logic        e_ovf;
    logic        e_idle;
  } vec_t;

  vec_t       tbl [17];
  logic [7:0] model_q [4][$];

  always #5 clk = ~clk;

  retorno_recirculacion #(.DATA_WIDTH(8), .DEPTH(4), .IDLE_CYCLES(2)) dut (
    .clk(clk), .reset(reset),
    .valid_inf0(valid_inf0), .valid_inf1(valid_inf1),
    .valid_inf2(valid_inf2), .valid_inf3(valid_inf3),
    .inf0(inf0), .inf1(inf1), .inf2(inf2), .inf3(inf3),
    .pause(pause),
    .valid_out0(valid_out0), .valid_out1(valid_out1),
    .valid_out2(valid_out2), .valid_out3(valid_out3),
    .out0(out0), .out1(out1), .out2(out2), .out3(out3),
    .fifo_full0(fifo_full0), .fifo_full1(fifo_full1),
    .fifo_full2(fifo_full2), .fifo_full3(fifo_full3),
    .fifo_empty0(fifo_empty0), .fifo_empty1(fifo_empty1),
    .fifo_empty2(fifo_empty2), .fifo_empty3(fifo_empty3),
    .overflow(overflow), .idle(idle)
  );

  assign vout_all  = {valid_out3, valid_out2, valid_out1, valid_out0};
  assign out_all   = {out3, out2, out1, out0};
  assign full_all  = {fifo_full3, fifo_full2, fifo_full1, fifo_full0};
  assign empty_all = {fifo_empty3, fifo_empty2, fifo_empty1, fifo_empty0};

  function automatic vec_t mk(input logic rst, input logic pse, input logic [3:0] vin,
                              input logic [31:0] din, input logic [3:0] e_vout,
                              input logic [31:0] e_out, input logic [3:0] e_full,
                              input logic [3:0] e_empty, input logic e_ovf, input logic e_idle);
    vec_t v;
    v.rst = rst; v.pse = pse; v.vin = vin; v.din = din;
    v.e_vout = e_vout; v.e_out = e_out; v.e_full = e_full;
    v.e_empty = e_empty; v.e_ovf = e_ovf; v.e_idle = e_idle;
    return v;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Drive inputs, then let one rising edge pass and settle 1ns before sampling.
  task automatic apply_stimulus(input logic rst, input logic pse, input logic [3:0] vin,
                                input logic [31:0] din);
    reset = rst;
    pause = pse;
    {valid_inf3, valid_inf2, valid_inf1, valid_inf0} = vin;
    {inf3, inf2, inf1, inf0} = din;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [31:0] exp_out;
    logic [3:0]  exp_v;
    logic [31:0] din;
    logic [3:0]  vin;

    //                 rst  pse  vin      din            vout     out            full     empty    ovf   idle
    tbl[0]  = mk(1'b1, 1'b0, 4'h0, 32'h00000000, 4'h0, 32'h00000000, 4'h0, 4'hF, 1'b0, 1'b0);
    tbl[1]  = mk(1'b0, 1'b0, 4'h0, 32'h00000000, 4'h0, 32'h00000000, 4'h0, 4'hF, 1'b0, 1'b0);
    tbl[2]  = mk(1'b0, 1'b0, 4'h0, 32'h00000000, 4'h0, 32'h00000000, 4'h0, 4'hF, 1'b0, 1'b1);
    tbl[3]  = mk(1'b0, 1'b0, 4'h0, 32'h00000000, 4'h0, 32'h00000000, 4'h0, 4'hF, 1'b0, 1'b1);
    tbl[4]  = mk(1'b0, 1'b0, 4'h4, 32'h00A50000, 4'h0, 32'h00000000, 4'h0, 4'hB, 1'b0, 1'b0);
    tbl[5]  = mk(1'b0, 1'b0, 4'h0, 32'h00000000, 4'h4, 32'h00A50000, 4'h0, 4'hF, 1'b0, 1'b0);
    tbl[6]  = mk(1'b0, 1'b0, 4'h0, 32'h00000000, 4'h0, 32'h00A50000, 4'h0, 4'hF, 1'b0, 1'b1);
    tbl[7]  = mk(1'b0, 1'b1, 4'h1, 32'h00000001, 4'h0, 32'h00A50000, 4'h0, 4'hE, 1'b0, 1'b0);
    tbl[8]  = mk(1'b0, 1'b1, 4'h1, 32'h00000002, 4'h0, 32'h00A50000, 4'h0, 4'hE, 1'b0, 1'b0);
    tbl[9]  = mk(1'b0, 1'b1, 4'h1, 32'h00000003, 4'h0, 32'h00A50000, 4'h0, 4'hE, 1'b0, 1'b0);
    tbl[10] = mk(1'b0, 1'b1, 4'h1, 32'h00000004, 4'h0, 32'h00A50000, 4'h1, 4'hE, 1'b0, 1'b0);
    tbl[11] = mk(1'b0, 1'b1, 4'h1, 32'h00000005, 4'h0, 32'h00A50000, 4'h1, 4'hE, 1'b1, 1'b0);
    tbl[12] = mk(1'b0, 1'b0, 4'h0, 32'h00000000, 4'h1, 32'h00A50001, 4'h0, 4'hE, 1'b1, 1'b0);
    tbl[13] = mk(1'b0, 1'b0, 4'h0, 32'h00000000, 4'h1, 32'h00A50002, 4'h0, 4'hE, 1'b1, 1'b0);
    tbl[14] = mk(1'b0, 1'b0, 4'h0, 32'h00000000, 4'h1, 32'h00A50003, 4'h0, 4'hE, 1'b1, 1'b0);
    tbl[15] = mk(1'b0, 1'b0, 4'h0, 32'h00000000, 4'h1, 32'h00A50004, 4'h0, 4'hF, 1'b1, 1'b0);
    tbl[16] = mk(1'b0, 1'b0, 4'h0, 32'h00000000, 4'h0, 32'h00A50004, 4'h0, 4'hF, 1'b1, 1'b1);

    for (int n = 0; n < 17; n++) begin
      apply_stimulus(tbl[n].rst, tbl[n].pse, tbl[n].vin, tbl[n].din);
      check_output($sformatf("vec%0d_vout", n),  32'(vout_all),  32'(tbl[n].e_vout));
      check_output($sformatf("vec%0d_out", n),   out_all,        tbl[n].e_out);
      check_output($sformatf("vec%0d_full", n),  32'(full_all),  32'(tbl[n].e_full));
      check_output($sformatf("vec%0d_empty", n), 32'(empty_all), 32'(tbl[n].e_empty));
      check_output($sformatf("vec%0d_ovf", n),   32'(overflow),  32'(tbl[n].e_ovf));
      check_output($sformatf("vec%0d_idle", n),  32'(idle),      32'(tbl[n].e_idle));
    end

    // Lane 1 full, then push+pop every cycle: stays full, never overflows.
    apply_stimulus(1'b1, 1'b0, 4'h0, 32'h0);
    for (int k = 0; k < 4; k++) begin
      apply_stimulus(1'b0, 1'b1, 4'h2, 32'(8'h10 + k) << 8);
    end
    check_output("full1_filled", 32'(full_all), 32'h2);
    for (int k = 0; k < 6; k++) begin
      apply_stimulus(1'b0, 1'b0, 4'h2, 32'h00001400);
      check_output($sformatf("pp_out1_%0d", k), 32'(out1), (k < 4) ? 32'(8'h10 + k) : 32'h14);
      check_output($sformatf("pp_vout1_%0d", k), 32'(valid_out1), 32'h1);
      check_output($sformatf("pp_full1_%0d", k), 32'(fifo_full1), 32'h1);
      check_output($sformatf("pp_ovf_%0d", k), 32'(overflow), 32'h0);
    end

    // All lanes concurrently, checked against a per-lane queue model.
    apply_stimulus(1'b1, 1'b0, 4'h0, 32'h0);
    exp_out = '0;
    for (int i = 0; i < 4; i++) model_q[i].delete();
    for (int k = 0; k < 10; k++) begin
      vin = (k < 8) ? 4'hF : 4'h0;
      for (int i = 0; i < 4; i++) din[8*i +: 8] = 8'(i * 16 + k);
      exp_v = '0;
      for (int i = 0; i < 4; i++) begin
        if (model_q[i].size() > 0) begin
          exp_v[i] = 1'b1;
          exp_out[8*i +: 8] = model_q[i].pop_front();
        end
        if (vin[i] && model_q[i].size() < 4) model_q[i].push_back(din[8*i +: 8]);
      end
      apply_stimulus(1'b0, 1'b0, vin, din);
      check_output($sformatf("all_vout_%0d", k), 32'(vout_all), 32'(exp_v));
      check_output($sformatf("all_out_%0d", k), out_all, exp_out);
    end

    // Reset mid-traffic discards held words and clears sticky overflow.
    apply_stimulus(1'b1, 1'b0, 4'h0, 32'h0);
    for (int k = 0; k < 5; k++) begin
      apply_stimulus(1'b0, 1'b1, {(k < 3), 3'b001}, {8'(8'hAA + k), 16'h0, 8'(k + 1)});
    end
    check_output("mid_ovf_set", 32'(overflow), 32'h1);
    check_output("mid_empty_before", 32'(empty_all), 32'h6);
    apply_stimulus(1'b1, 1'b0, 4'h0, 32'h0);
    check_output("mid_empty_after", 32'(empty_all), 32'hF);
    check_output("mid_vout_reset", 32'(vout_all), 32'h0);
    check_output("mid_ovf_clear", 32'(overflow), 32'h0);
    for (int k = 0; k < 5; k++) begin
      apply_stimulus(1'b0, 1'b0, 4'h0, 32'h0);
      check_output($sformatf("mid_vout_%0d", k), 32'(vout_all), 32'h0);
      check_output($sformatf("mid_out_%0d", k), out_all, 32'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
